// File: rtl/dds_phase_bank.sv
// dds_phase_bank: multi-channel DDS phase accumulator bank with shadowed
// frequency/offset registers and a single coherent update strobe.
// Ports: clk/rst (sync, active-high); enable advances all accumulators;
//   wr_en/wr_ch/wr_sel/wr_data write one shadow register (sel 0 = freq, 1 = offset);
//   update commits every shadow register at once; sync[n] clears accumulator n;
//   phase_out packs channel n at [n*OUT_SIZE +: OUT_SIZE]; wrap[n] flags an
//   accumulator overflow aligned with phase_out; out_valid marks post-reset data.
module dds_phase_bank #(
  parameter int ACC_SIZE = 28,
  parameter int NUM_CH   = 4,
  parameter int OUT_SIZE = 12,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       wr_en,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic                       wr_sel,
  input  logic [ACC_SIZE-1:0]        wr_data,
  input  logic                       update,
  input  logic [NUM_CH-1:0]          sync,
  output logic [NUM_CH*OUT_SIZE-1:0] phase_out,
  output logic [NUM_CH-1:0]          wrap,
  output logic                       out_valid
);

  // Shadow, active and accumulator state per channel.
  logic [ACC_SIZE-1:0] fw_sh_q  [NUM_CH];
  logic [ACC_SIZE-1:0] fw_sh_d  [NUM_CH];
  logic [ACC_SIZE-1:0] off_sh_q [NUM_CH];
  logic [ACC_SIZE-1:0] off_sh_d [NUM_CH];
  logic [ACC_SIZE-1:0] fw_act_q [NUM_CH];
  logic [ACC_SIZE-1:0] fw_act_d [NUM_CH];
  logic [ACC_SIZE-1:0] off_act_q[NUM_CH];
  logic [ACC_SIZE-1:0] off_act_d[NUM_CH];
  logic [ACC_SIZE-1:0] acc_q    [NUM_CH];
  logic [ACC_SIZE-1:0] acc_d    [NUM_CH];
  logic [NUM_CH-1:0]   carry_q;
  logic [NUM_CH-1:0]   carry_d;

  // Output stage.
  logic [NUM_CH*OUT_SIZE-1:0] phase_q;
  logic [NUM_CH*OUT_SIZE-1:0] phase_d;
  logic [NUM_CH-1:0]          wrap_q;
  logic [NUM_CH-1:0]          wrap_d;
  logic                       vld_pre_q;
  logic                       vld_pre_d;
  logic                       out_valid_q;
  logic                       out_valid_d;

  // Combinational helpers.
  logic [ACC_SIZE:0]   acc_sum [NUM_CH];
  logic [ACC_SIZE-1:0] pos_sum [NUM_CH];

  always_comb begin
    phase_d     = '0;
    carry_d     = '0;
    vld_pre_d   = 1'b1;
    // out_valid trails the first post-reset edge by one cycle, matching the
    // acc -> phase_out register stage.
    out_valid_d = vld_pre_q;
    // The carry registered with the accumulator is re-registered here so the
    // flag lines up with the first post-overflow phase value.
    wrap_d      = carry_q;

    for (int n = 0; n < NUM_CH; n++) begin
      fw_sh_d[n]  = fw_sh_q[n];
      off_sh_d[n] = off_sh_q[n];
      if (wr_en && (wr_ch == CH_W'(n))) begin
        if (wr_sel) begin
          off_sh_d[n] = wr_data;
        end else begin
          fw_sh_d[n] = wr_data;
        end
      end

      // Committing from the next-shadow value lets a same-cycle write pass
      // straight through to the active register.
      fw_act_d[n]  = update ? fw_sh_d[n]  : fw_act_q[n];
      off_act_d[n] = update ? off_sh_d[n] : off_act_q[n];

      acc_sum[n] = {1'b0, acc_q[n]} + {1'b0, fw_act_q[n]};
      if (sync[n]) begin
        acc_d[n] = '0;
      end else if (enable) begin
        acc_d[n]   = acc_sum[n][ACC_SIZE-1:0];
        carry_d[n] = acc_sum[n][ACC_SIZE];
      end else begin
        acc_d[n] = acc_q[n];
      end

      // Offset add wraps silently; only the accumulator carry drives wrap.
      pos_sum[n] = acc_q[n] + off_act_q[n];
      phase_d[n*OUT_SIZE +: OUT_SIZE] = OUT_SIZE'(pos_sum[n] >> (ACC_SIZE - OUT_SIZE));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fw_sh_q     <= '{default: '0};
      off_sh_q    <= '{default: '0};
      fw_act_q    <= '{default: '0};
      off_act_q   <= '{default: '0};
      acc_q       <= '{default: '0};
      carry_q     <= '0;
      phase_q     <= '0;
      wrap_q      <= '0;
      vld_pre_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      fw_sh_q     <= fw_sh_d;
      off_sh_q    <= off_sh_d;
      fw_act_q    <= fw_act_d;
      off_act_q   <= off_act_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      phase_q     <= phase_d;
      wrap_q      <= wrap_d;
      vld_pre_q   <= vld_pre_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign phase_out = phase_q;
  assign wrap      = wrap_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dds_phase_bank.sv
// tb_dds_phase_bank: self-checking bench for dds_phase_bank (28-bit acc,
// 4 channels, 12-bit output). Each cycle's stimulus carries the outputs
// expected right after that clock edge; they pass through a scoreboard queue.
module tb_dds_phase_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic        wr_sel;
  logic [27:0] wr_data;
  logic        update;
  logic [3:0]  sync;
  logic [47:0] phase_out;
  logic [3:0]  wrap;
  logic        out_valid;

  dds_phase_bank dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .update    (update),
    .sync      (sync),
    .phase_out (phase_out),
    .wrap      (wrap),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  ch;
    logic        sel;
    logic [27:0] dat;
    logic        upd;
    logic [3:0]  sy;
    logic [47:0] ex_ph;
    logic [3:0]  ex_wrap;
    logic        ex_vld;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic logic [47:0] ph(input logic [11:0] c0, input logic [11:0] c1,
                                     input logic [11:0] c2, input logic [11:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic vec_t mk(input logic r, input logic e, input logic we,
                              input logic [1:0] ch, input logic sel, input logic [27:0] d,
                              input logic up, input logic [3:0] sy,
                              input logic [47:0] eph, input logic [3:0] ew, input logic ev);
    vec_t v;
    v.rst = r; v.en = e; v.we = we; v.ch = ch; v.sel = sel; v.dat = d;
    v.upd = up; v.sy = sy; v.ex_ph = eph; v.ex_wrap = ew; v.ex_vld = ev;
    return v;
  endfunction

  task automatic add(input logic r, input logic e, input logic we,
                     input logic [1:0] ch, input logic sel, input logic [27:0] d,
                     input logic up, input logic [3:0] sy,
                     input logic [47:0] eph, input logic [3:0] ew, input logic ev);
    tbl.push_back(mk(r, e, we, ch, sel, d, up, sy, eph, ew, ev));
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, want %h", name, step_no, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; enable = v.en; wr_en = v.we; wr_ch = v.ch; wr_sel = v.sel;
    wr_data = v.dat; update = v.upd; sync = v.sy;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("phase_out", phase_out, e.ex_ph);
    chk("wrap", {44'd0, wrap}, {44'd0, e.ex_wrap});
    chk("out_valid", {47'd0, out_valid}, {47'd0, e.ex_vld});
    step_no++;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) step(tbl[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_lo, f_lo, c_lo, e_lo, e_hi;
    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_sel = 1'b0;
    wr_data = 28'd0; update = 1'b0; sync = 4'd0;

    // Reset and shadow isolation: a write without update never reaches ch0.
    a_lo = tbl.size();
    add(1, 0, 0, 0, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 0);
    add(1, 0, 0, 0, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 0);
    add(0, 1, 1, 0, 0, 28'h1000000, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 0);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    // Mid-run reset: everything clears, and a bare update commits zeros.
    f_lo = tbl.size();
    add(1, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 0);
    add(0, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 0);
    add(0, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0, 1, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    // Offset only on ch1: constant 0x800, one cycle after the update.
    c_lo = tbl.size();
    add(0, 1, 1, 1, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 1, 1, 1, 28'h8000000, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       1, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(0, 12'h800, 0, 0), 4'h0, 1);
    // Sync and enable: ch0 restarts, ch1 continues; holds when disabled;
    // offset change still visible with enable low.
    e_lo = tbl.size();
    add(1, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 0);
    add(0, 1, 1, 0, 0, 28'h1000000, 0, 4'h0, ph(0, 0, 0, 0), 4'h0, 0);
    add(0, 1, 1, 1, 0, 28'h1000000, 1, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(0, 0, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h100, 12'h100, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h200, 12'h200, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h1, ph(12'h300, 12'h300, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h000, 12'h400, 0, 0), 4'h0, 1);
    add(0, 1, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h100, 12'h500, 0, 0), 4'h0, 1);
    add(0, 0, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h200, 12'h600, 0, 0), 4'h0, 1);
    add(0, 0, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h200, 12'h600, 0, 0), 4'h0, 1);
    add(0, 0, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h200, 12'h600, 0, 0), 4'h0, 1);
    add(0, 0, 0, 0, 0, 28'h0,       0, 4'h2, ph(12'h200, 12'h600, 0, 0), 4'h0, 1);
    add(0, 0, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h200, 12'h000, 0, 0), 4'h0, 1);
    add(0, 0, 1, 0, 1, 28'h4000000, 1, 4'h0, ph(12'h200, 12'h000, 0, 0), 4'h0, 1);
    add(0, 0, 0, 0, 0, 28'h0,       0, 4'h0, ph(12'h600, 12'h000, 0, 0), 4'h0, 1);
    e_hi = tbl.size();

    run_rows(a_lo, f_lo);

    // Tuning and wrap on ch0: 0x100 steps, wrap once every 16 cycles.
    step(mk(0, 1, 0, 0, 0, 28'h0, 1, 4'h0, ph(0, 0, 0, 0), 4'h0, 1));
    for (int i = 0; i <= 40; i++)
      step(mk(0, 1, 0, 0, 0, 28'h0, 0, 4'h0, ph(12'(i * 256), 0, 0, 0),
              {3'b000, (i > 0) && (i % 16 == 0)}, 1));

    run_rows(f_lo, c_lo);
    run_rows(c_lo, e_lo);

    // Coherent update with write-through on ch3.
    step(mk(0, 1, 1, 2, 0, 28'h2000000, 0, 4'h0, ph(0, 12'h800, 0, 0), 4'h0, 1));
    step(mk(0, 1, 1, 3, 0, 28'h2000000, 0, 4'h0, ph(0, 12'h800, 0, 0), 4'h0, 1));
    step(mk(0, 1, 1, 3, 0, 28'h4000000, 1, 4'h0, ph(0, 12'h800, 0, 0), 4'h0, 1));
    for (int i = 0; i < 10; i++)
      step(mk(0, 1, 0, 0, 0, 28'h0, 0, 4'h0,
              ph(0, 12'h800, 12'(i * 512), 12'(i * 1024)),
              {(i > 0) && (i % 4 == 0), (i > 0) && (i % 8 == 0), 2'b00}, 1));

    run_rows(e_lo, e_hi);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
